csr_mtrap: RTL and testbench
============================

# csr_mtrap

Machine-mode CSR file with trap and interrupt sequencing. Successor to the fixed 32-bit CSR block: parametrised in data width and counter width, and it owns the trap state itself. It updates mepc/mcause/mtval/mstatus on trap entry and mret, synchronises and prioritises the three machine interrupt lines, and supplies the trap vector to the fetch stage. It sits beside the pipeline; reads come from EXE, writes and trap events come from WB.

## Interface
- XLEN, 32: CSR data width; 32 only in this generation, parametrised for the package.
- CNT_WIDTH, 64: mcycle/minstret width, legal 33..64; bits above CNT_WIDTH read as zero.
- HART_ID, 0: value returned by mhartid.
- MTVEC_RESET, 0: reset value of mtvec.
- clk_i  in  1  single clock.
- rst_ni  in  1  asynchronous, active-low reset.
- raddr_i  in  12  CSR read address.
- rdata_o  out  XLEN  combinational read data.
- we_i  in  1  CSR write enable.
- waddr_i  in  12  CSR write address.
- wdata_i  in  XLEN  CSR write data.
- instret_incr_i  in  1  one instruction retired this cycle.
- irq_ext_i, irq_timer_i, irq_soft_i  in  1 each  asynchronous level interrupt sources.
- irq_req_o  out  1  interrupt request to pipeline.
- irq_cause_o  out  4  code of the highest-priority pending interrupt.
- irq_ack_i  in  1  pipeline takes the interrupt this cycle.
- trap_i  in  1  synchronous exception taken this cycle.
- trap_cause_i  in  4  exception code.
- trap_pc_i  in  XLEN  PC to save, used for exceptions and interrupts.
- trap_tval_i  in  XLEN  mtval value; exceptions only.
- mret_i  in  1  mret retires this cycle.
- trap_vec_o  out  XLEN  redirect target for the current trap or interrupt.
- mepc_o  out  XLEN  current mepc, used for the mret redirect.

## Operation
- Reset:
  - all CSRs 0 except mtvec=MTVEC_RESET;
  - counters and synchronisers 0;
  - irq_req_o=0, irq_cause_o=0.
- Read-only CSRs:
  - mvendorid=0, marchid=22, mimpid=0, mhartid=HART_ID;
  - misa={2'b01,4'b0,26'h0000100} (RV32I);
  - unmapped addresses read 0.
- WARL masks, applied on write and in the read bypass:
  - mstatus keeps only MIE[3] and MPIE[7]; MPP[12:11] always reads 2'b11.
  - mie keeps only bits 3, 7, 11.
  - mtvec mode[1:0] values 2 and 3 are stored as 0.
  - mepc[1:0] forced 0.
  - mcountinhibit keeps only bits 0 and 2.
- mip is read-only, bits 11/7/3 = synchronised ext/timer/soft; writes to mip are ignored.
- Interrupt request:
  - pending = mip & mie.
  - irq_req_o = mstatus.MIE & |pending.
  - Priority ext(11) > soft(3) > timer(7); irq_cause_o = winner, 0 when nothing is pending.
- Event priority in one cycle: trap_i > (irq_ack_i & irq_req_o) > mret_i. Only the winning event acts. irq_ack_i while irq_req_o=0 is ignored.
- Trap or interrupt entry:
  - mepc←trap_pc_i&~3;
  - mcause←{interrupt,0…,code};
  - mtval←trap_tval_i for exceptions, 0 for interrupts;
  - MPIE←MIE, MIE←0.
- mret: MIE←MPIE, MPIE←1.
- A CSR write in the same cycle as a trap, interrupt or mret is dropped for mstatus/mepc/mcause/mtval. Writes to all other CSRs proceed.
- trap_vec_o:
  - {mtvec[XLEN-1:2],2'b00} in direct mode and for all exceptions;
  - base + 4*cause for interrupts in vectored mode.
- Counters:
  - mcycle increments each cycle unless mcountinhibit[0] is set.
  - minstret increments on instret_incr_i unless mcountinhibit[2] is set.
  - Both wrap to 0 at 2^CNT_WIDTH.
  - A write to a low or high half replaces that half and suppresses that counter's increment in that cycle.
  - cycle/cycleh aliases read the mcycle halves.

## Timing
- Write latency 1 cycle. Read bypass: raddr_i==waddr_i with we_i high returns the masked wdata_i in the same cycle.
- Interrupt lines use 2-flop synchronisers. A line rising before edge N is visible in mip, and in irq_req_o, after edge N+1.
- irq_req_o and irq_cause_o are combinational from registered state. They are held until acknowledged or until the source or enable drops. No latching: a source that drops before ack withdraws the request.
- After an ack, MIE=0 on the next cycle, so irq_req_o falls 1 cycle after ack.
- trap_vec_o is valid in the same cycle as trap_i or irq_ack_i.
- rst_ni assertion mid-operation clears all state immediately; the first increment follows the first edge after release.

## Structure
- csr_pkg holds:
  - all 12-bit CSR addresses (incl. mcountinhibit, minstreth);
  - mstatus/mip bit positions;
  - interrupt cause codes 3/7/11;
  - tvec mode enum;
  - misa constant.
- Sub-module csr_counter (CNT_WIDTH, inhibit, increment, half-write), instantiated for mcycle and minstret.

## Test plan
- Reset and misa: release rst_ni, read misa → 0x40000100, mtvec=MTVEC_RESET, irq_req_o=0.
- WARL masking:
  - write mstatus=0xFFFFFFFF → reads 0x00001888;
  - write mtvec=0x1003 → reads 0x1000;
  - same-cycle read returns the masked value.
- Exception: trap_i, cause 2, pc 0x80000106, tval 0xDEAD, MIE=1, mtvec=0x100 →
  - mepc=0x80000104, mcause=2, mtval=0xDEAD;
  - MIE=0, MPIE=1;
  - trap_vec_o=0x100.
- Vectored interrupt priority: mtvec=0x201, mie=0x888, MIE=1, raise timer+ext together →
  - irq_req_o after 2 edges, irq_cause_o=11;
  - on ack: mcause=0x8000000B, trap_vec_o=0x22C.
- Simultaneous events: trap_i+irq_ack_i+write mepc=0x40 in one cycle → exception recorded, mepc=trap_pc_i; then mret → MIE=1.
- Counters:
  - write mcycle=0xFFFFFFFF → next read mcycleh=1;
  - mcountinhibit=5 freezes mcycle and minstret;
  - CNT_WIDTH=40 wraps 0xFF_FFFFFFFF → 0.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR addresses, bit positions, cause codes and WARL masks for the machine-mode CSR file.
// Constants and pure helper functions only, so there is no latency or backpressure to describe.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MSIP     = 3;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

  localparam logic [3:0] IRQ_SOFT  = 4'd3;
  localparam logic [3:0] IRQ_TIMER = 4'd7;
  localparam logic [3:0] IRQ_EXT   = 4'd11;

  typedef enum logic [1:0] {
    TVEC_DIRECT   = 2'd0,
    TVEC_VECTORED = 2'd1
  } tvec_mode_e;

  localparam logic [31:0] MISA_RV32I      = {2'b01, 4'b0, 26'h0000100};
  localparam logic [31:0] MARCHID_VAL     = 32'd22;
  localparam logic [31:0] MSTATUS_WMASK   = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_MPP_RO  = 32'h0000_1800;
  localparam logic [31:0] MIE_WMASK       = 32'h0000_0888;
  localparam logic [31:0] MCOUNTINH_WMASK = 32'h0000_0005;

  // Reserved modes collapse to direct so the fetch target is always defined.
  function automatic logic [1:0] tvec_legal(input logic [1:0] mode);
    tvec_legal = (mode == TVEC_VECTORED) ? TVEC_VECTORED : TVEC_DIRECT;
  endfunction

  function automatic logic csr_writable(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
      CSR_MCOUNTINHIBIT, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET,
      CSR_MINSTRETH: csr_writable = 1'b1;
      default:       csr_writable = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running CNT_WIDTH counter with inhibit and independent 32-bit half writes.
// Writes land after one edge and take precedence over that cycle's increment; never stalls.
module csr_counter
  import csr_pkg::*;
#(
  parameter int CNT_WIDTH = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inhibit_i,
  input  logic        incr_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o
);

  localparam int HI_W = CNT_WIDTH - 32;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i) cnt_d[31:0] = wdata_i;
    if (wr_hi_i) cnt_d[CNT_WIDTH-1:32] = wdata_i[HI_W-1:0];
    if (!wr_lo_i && !wr_hi_i && incr_i && !inhibit_i)
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  always_comb begin
    value_o = '0;
    value_o[CNT_WIDTH-1:0] = cnt_q;
  end

endmodule

// File: rtl/csr_mtrap.sv
// Machine-mode CSR file: WARL CSRs, counters, interrupt sync/priority, trap entry and mret.
// Writes take effect after one edge, reads and trap vector are combinational; no backpressure.
module csr_mtrap
  import csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              CNT_WIDTH   = 64,
  parameter logic [XLEN-1:0] HART_ID     = '0,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [11:0]     raddr_i,
  output logic [XLEN-1:0] rdata_o,
  input  logic            we_i,
  input  logic [11:0]     waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            instret_incr_i,
  input  logic            irq_ext_i,
  input  logic            irq_timer_i,
  input  logic            irq_soft_i,
  output logic            irq_req_o,
  output logic [3:0]      irq_cause_o,
  input  logic            irq_ack_i,
  input  logic            trap_i,
  input  logic [3:0]      trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] trap_vec_o,
  output logic [XLEN-1:0] mepc_o
);

  localparam logic [31:0] CNT_HI_MASK = 32'hFFFF_FFFF >> (64 - CNT_WIDTH);

  logic [2:0]      sync1_q, sync2_q;  // {ext, timer, soft}
  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] mcountinh_q, mcountinh_d;

  logic [XLEN-1:0] mip, pending, mstatus_rd, tvec_base;
  logic [63:0]     mcycle_val, minstret_val;
  logic            take_trap, take_irq, take_mret, trap_evt;

  function automatic logic [XLEN-1:0] warl_view(input logic [11:0] a, input logic [XLEN-1:0] d);
    warl_view = d;
    case (a)
      CSR_MSTATUS:              warl_view = (d & XLEN'(MSTATUS_WMASK)) | XLEN'(MSTATUS_MPP_RO);
      CSR_MIE:                  warl_view = d & XLEN'(MIE_WMASK);
      CSR_MTVEC:                warl_view = {d[XLEN-1:2], tvec_legal(d[1:0])};
      CSR_MEPC:                 warl_view = {d[XLEN-1:2], 2'b00};
      CSR_MCOUNTINHIBIT:        warl_view = d & XLEN'(MCOUNTINH_WMASK);
      CSR_MCYCLEH, CSR_MINSTRETH: warl_view = d & XLEN'(CNT_HI_MASK);
      default: ;
    endcase
  endfunction

  always_comb begin
    mip = '0;
    mip[MIP_MEIP] = sync2_q[2];
    mip[MIP_MTIP] = sync2_q[1];
    mip[MIP_MSIP] = sync2_q[0];
  end

  assign pending   = mip & mie_q;
  assign irq_req_o = mstatus_mie_q & (|pending);

  always_comb begin
    irq_cause_o = 4'd0;
    if (pending[MIP_MEIP])      irq_cause_o = IRQ_EXT;
    else if (pending[MIP_MSIP]) irq_cause_o = IRQ_SOFT;
    else if (pending[MIP_MTIP]) irq_cause_o = IRQ_TIMER;
  end

  // Exception beats interrupt beats mret; an ack without a live request is ignored.
  assign take_trap = trap_i;
  assign take_irq  = ~trap_i & irq_ack_i & irq_req_o;
  assign take_mret = ~trap_i & ~take_irq & mret_i;
  assign trap_evt  = take_trap | take_irq | take_mret;

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    mcountinh_d    = mcountinh_q;

    if (we_i) begin
      case (waddr_i)
        CSR_MIE:           mie_d       = warl_view(waddr_i, wdata_i);
        CSR_MTVEC:         mtvec_d     = warl_view(waddr_i, wdata_i);
        CSR_MCOUNTINHIBIT: mcountinh_d = warl_view(waddr_i, wdata_i);
        default: ;
      endcase
    end

    // Trap state belongs to the event when both arrive together.
    if (we_i && !trap_evt) begin
      case (waddr_i)
        CSR_MSTATUS: begin
          mstatus_mie_d  = wdata_i[MSTATUS_MIE];
          mstatus_mpie_d = wdata_i[MSTATUS_MPIE];
        end
        CSR_MEPC:   mepc_d   = warl_view(waddr_i, wdata_i);
        CSR_MCAUSE: mcause_d = wdata_i;
        CSR_MTVAL:  mtval_d  = wdata_i;
        default: ;
      endcase
    end

    if (take_trap || take_irq) begin
      mepc_d             = {trap_pc_i[XLEN-1:2], 2'b00};
      mcause_d           = '0;
      mcause_d[XLEN-1]   = take_irq;
      mcause_d[3:0]      = take_irq ? irq_cause_o : trap_cause_i;
      mtval_d            = take_irq ? '0 : trap_tval_i;
      mstatus_mpie_d     = mstatus_mie_q;
      mstatus_mie_d      = 1'b0;
    end else if (take_mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mcountinh_q    <= '0;
    end else begin
      sync1_q        <= {irq_ext_i, irq_timer_i, irq_soft_i};
      sync2_q        <= sync1_q;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mcountinh_q    <= mcountinh_d;
    end
  end

  csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .inhibit_i (mcountinh_q[0]),
    .incr_i    (1'b1),
    .wr_lo_i   (we_i && (waddr_i == CSR_MCYCLE)),
    .wr_hi_i   (we_i && (waddr_i == CSR_MCYCLEH)),
    .wdata_i   (wdata_i[31:0]),
    .value_o   (mcycle_val)
  );

  csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .inhibit_i (mcountinh_q[2]),
    .incr_i    (instret_incr_i),
    .wr_lo_i   (we_i && (waddr_i == CSR_MINSTRET)),
    .wr_hi_i   (we_i && (waddr_i == CSR_MINSTRETH)),
    .wdata_i   (wdata_i[31:0]),
    .value_o   (minstret_val)
  );

  always_comb begin
    mstatus_rd = XLEN'(MSTATUS_MPP_RO);
    mstatus_rd[MSTATUS_MIE]  = mstatus_mie_q;
    mstatus_rd[MSTATUS_MPIE] = mstatus_mpie_q;
  end

  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      CSR_MARCHID:               rdata_o = XLEN'(MARCHID_VAL);
      CSR_MHARTID:               rdata_o = HART_ID;
      CSR_MISA:                  rdata_o = XLEN'(MISA_RV32I);
      CSR_MSTATUS:               rdata_o = mstatus_rd;
      CSR_MIE:                   rdata_o = mie_q;
      CSR_MTVEC:                 rdata_o = mtvec_q;
      CSR_MEPC:                  rdata_o = mepc_q;
      CSR_MCAUSE:                rdata_o = mcause_q;
      CSR_MTVAL:                 rdata_o = mtval_q;
      CSR_MIP:                   rdata_o = mip;
      CSR_MCOUNTINHIBIT:         rdata_o = mcountinh_q;
      CSR_MCYCLE, CSR_CYCLE:     rdata_o = mcycle_val[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:   rdata_o = mcycle_val[63:32];
      CSR_MINSTRET:              rdata_o = minstret_val[31:0];
      CSR_MINSTRETH:             rdata_o = minstret_val[63:32];
      default: ;
    endcase
    if (we_i && (raddr_i == waddr_i) && csr_writable(waddr_i))
      rdata_o = warl_view(waddr_i, wdata_i);
  end

  assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};

  always_comb begin
    trap_vec_o = tvec_base;
    if (!trap_i && irq_req_o && (mtvec_q[1:0] == TVEC_VECTORED))
      trap_vec_o = tvec_base + XLEN'({irq_cause_o, 2'b00});
  end

  assign mepc_o = mepc_q;

endmodule

// File: tb/tb_csr_mtrap.sv
// Directed and randomized checks of csr_mtrap against constants and a register-level model.
`timescale 1ns/1ps
module tb_csr_mtrap;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [11:0] raddr_i, waddr_i;
  logic [31:0] rdata_o, wdata_i;
  logic        we_i, instret_incr_i;
  logic        irq_ext_i, irq_timer_i, irq_soft_i;
  logic        irq_req_o, irq_ack_i;
  logic [3:0]  irq_cause_o, trap_cause_i;
  logic        trap_i, mret_i;
  logic [31:0] trap_pc_i, trap_tval_i, trap_vec_o, mepc_o;

  int checks = 0;
  int errors = 0;

  csr_mtrap #(.XLEN(32), .CNT_WIDTH(40), .HART_ID(32'd5), .MTVEC_RESET(32'h100)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .raddr_i(raddr_i), .rdata_o(rdata_o),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .instret_incr_i(instret_incr_i),
    .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i), .irq_soft_i(irq_soft_i),
    .irq_req_o(irq_req_o), .irq_cause_o(irq_cause_o), .irq_ack_i(irq_ack_i),
    .trap_i(trap_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
    .trap_tval_i(trap_tval_i), .mret_i(mret_i), .trap_vec_o(trap_vec_o), .mepc_o(mepc_o)
  );

  always #50 clk_i = ~clk_i;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1);
  end

  localparam logic [11:0] A_MSTATUS = 12'h300, A_MISA = 12'h301, A_MIE = 12'h304,
                          A_MTVEC = 12'h305, A_MCINH = 12'h320, A_MEPC = 12'h341,
                          A_MCAUSE = 12'h342, A_MTVAL = 12'h343, A_MIP = 12'h344,
                          A_MCYCLE = 12'hB00, A_MINSTRET = 12'hB02, A_MCYCLEH = 12'hB80,
                          A_CYCLE = 12'hC00, A_CYCLEH = 12'hC80, A_MARCHID = 12'hF12,
                          A_MHARTID = 12'hF14;

  logic [11:0] RA [8];
  logic [31:0] mdl [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rchk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    raddr_i = a;
    #1;
    chk(tag, rdata_o, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    tick();
    we_i = 1'b0;
  endtask

  // Architectural effect of a software write, as seen on a later read.
  function automatic logic [31:0] mdl_write(input int idx, input logic [31:0] d);
    case (idx)
      0:       return (d & 32'h88) | 32'h1800;
      1:       return d & 32'h888;
      2:       return (d[1:0] >= 2'd2) ? (d & 32'hFFFF_FFFC) : d;
      3:       return d & 32'hFFFF_FFFC;
      4, 5:    return d;
      6:       return d & 32'h5;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    RA = '{A_MSTATUS, A_MIE, A_MTVEC, A_MEPC, A_MCAUSE, A_MTVAL, A_MCINH, A_MIP};
    rst_ni = 1'b0; raddr_i = '0; waddr_i = '0; wdata_i = '0; we_i = 1'b0;
    instret_incr_i = 1'b0; irq_ext_i = 1'b0; irq_timer_i = 1'b0; irq_soft_i = 1'b0;
    irq_ack_i = 1'b0; trap_i = 1'b0; trap_cause_i = '0; trap_pc_i = '0;
    trap_tval_i = '0; mret_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Reset state
    rchk("misa", A_MISA, 32'h4000_0100);
    rchk("mtvec_reset", A_MTVEC, 32'h100);
    rchk("mstatus_reset", A_MSTATUS, 32'h1800);
    rchk("mhartid", A_MHARTID, 32'd5);
    rchk("marchid", A_MARCHID, 32'd22);
    rchk("unmapped", 12'h7C0, 32'h0);
    rchk("mcycle_reset", A_MCYCLE, 32'h0);
    chk("irq_req_reset", 32'(irq_req_o), 32'h0);
    chk("irq_cause_reset", 32'(irq_cause_o), 32'h0);

    // WARL masking with same-cycle bypass
    we_i = 1'b1; waddr_i = A_MSTATUS; wdata_i = 32'hFFFF_FFFF;
    rchk("mstatus_bypass", A_MSTATUS, 32'h1888);
    tick(); we_i = 1'b0;
    rchk("mstatus_warl", A_MSTATUS, 32'h1888);
    we_i = 1'b1; waddr_i = A_MTVEC; wdata_i = 32'h1003;
    rchk("mtvec_bypass", A_MTVEC, 32'h1000);
    tick(); we_i = 1'b0;
    rchk("mtvec_warl", A_MTVEC, 32'h1000);
    wr(A_MIE, 32'hFFFF_FFFF);  rchk("mie_warl", A_MIE, 32'h888);
    wr(A_MEPC, 32'h123);       rchk("mepc_warl", A_MEPC, 32'h120);
    wr(A_MCINH, 32'hFF);       rchk("mcinh_warl", A_MCINH, 32'h5);
    wr(A_MCINH, 32'h0);
    wr(A_MIP, 32'hFFFF_FFFF);  rchk("mip_ro", A_MIP, 32'h0);

    // Exception entry
    wr(A_MTVEC, 32'h100);
    wr(A_MSTATUS, 32'h8);
    trap_i = 1'b1; trap_cause_i = 4'd2; trap_pc_i = 32'h8000_0106; trap_tval_i = 32'hDEAD;
    #1 chk("exc_vec", trap_vec_o, 32'h100);
    tick(); trap_i = 1'b0;
    rchk("exc_mepc", A_MEPC, 32'h8000_0104);
    chk("exc_mepc_o", mepc_o, 32'h8000_0104);
    rchk("exc_mcause", A_MCAUSE, 32'h2);
    rchk("exc_mtval", A_MTVAL, 32'hDEAD);
    rchk("exc_mstatus", A_MSTATUS, 32'h1880);

    // Vectored interrupt, priority and sync latency
    wr(A_MTVEC, 32'h201);
    wr(A_MIE, 32'h888);
    wr(A_MSTATUS, 32'h8);
    irq_timer_i = 1'b1; irq_ext_i = 1'b1;
    tick();
    chk("irq_req_1edge", 32'(irq_req_o), 32'h0);
    tick();
    chk("irq_req_2edge", 32'(irq_req_o), 32'h1);
    chk("irq_cause_ext", 32'(irq_cause_o), 32'd11);
    rchk("mip_ext_timer", A_MIP, 32'h880);
    irq_ack_i = 1'b1; trap_pc_i = 32'h3002;
    #1 chk("irq_vec", trap_vec_o, 32'h22C);
    tick(); irq_ack_i = 1'b0;
    rchk("irq_mcause", A_MCAUSE, 32'h8000_000B);
    rchk("irq_mepc", A_MEPC, 32'h3000);
    rchk("irq_mtval", A_MTVAL, 32'h0);
    rchk("irq_mstatus", A_MSTATUS, 32'h1880);
    chk("irq_req_after_ack", 32'(irq_req_o), 32'h0);
    irq_ext_i = 1'b0;
    tick(); tick();
    chk("irq_cause_timer", 32'(irq_cause_o), 32'd7);
    irq_soft_i = 1'b1;
    tick(); tick();
    chk("irq_cause_soft", 32'(irq_cause_o), 32'd3);
    mret_i = 1'b1;
    tick(); mret_i = 1'b0;
    rchk("mret_mstatus", A_MSTATUS, 32'h1888);
    chk("irq_req_mret", 32'(irq_req_o), 32'h1);
    irq_soft_i = 1'b0; irq_timer_i = 1'b0;
    tick();
    chk("irq_req_hold", 32'(irq_req_o), 32'h1);
    tick();
    chk("irq_req_drop", 32'(irq_req_o), 32'h0);
    chk("irq_cause_drop", 32'(irq_cause_o), 32'h0);

    // Simultaneous trap, ack, mret and mepc write
    irq_soft_i = 1'b1;
    tick(); tick();
    chk("irq_req_sim", 32'(irq_req_o), 32'h1);
    trap_i = 1'b1; trap_cause_i = 4'd5; trap_pc_i = 32'h503; trap_tval_i = 32'h77;
    irq_ack_i = 1'b1; mret_i = 1'b1;
    we_i = 1'b1; waddr_i = A_MEPC; wdata_i = 32'h40;
    #1 chk("sim_vec", trap_vec_o, 32'h200);
    tick();
    trap_i = 1'b0; irq_ack_i = 1'b0; mret_i = 1'b0; we_i = 1'b0; irq_soft_i = 1'b0;
    rchk("sim_mepc", A_MEPC, 32'h500);
    rchk("sim_mcause", A_MCAUSE, 32'h5);
    rchk("sim_mtval", A_MTVAL, 32'h77);
    rchk("sim_mstatus", A_MSTATUS, 32'h1880);
    mret_i = 1'b1;
    tick(); mret_i = 1'b0;
    rchk("sim_mret", A_MSTATUS, 32'h1888);
    tick(); tick();
    irq_ack_i = 1'b1;
    tick(); irq_ack_i = 1'b0;
    rchk("stray_ack_mcause", A_MCAUSE, 32'h5);
    rchk("stray_ack_mstatus", A_MSTATUS, 32'h1888);

    // Randomized CSR writes, traps and mrets against the model
    for (int i = 0; i < 7; i++) begin
      logic [31:0] d0;
      d0 = $urandom;
      wr(RA[i], d0);
      mdl[i] = mdl_write(i, d0);
    end
    mdl[7] = 32'h0;
    for (int n = 0; n < 300; n++) begin
      int idx, ridx, ev;
      logic [31:0] d;
      bit dow;
      idx = $urandom_range(0, 7);
      d   = $urandom;
      dow = 1'($urandom_range(0, 1));
      ev  = $urandom_range(0, 5);
      if (dow && ev > 1)  ridx = idx;
      else if (dow)       ridx = (idx + 1 + $urandom_range(0, 6)) % 8;
      else                ridx = $urandom_range(0, 7);
      we_i = dow; waddr_i = RA[idx]; wdata_i = d;
      trap_i = (ev == 0); mret_i = (ev == 1);
      trap_cause_i = 4'($urandom); trap_pc_i = $urandom; trap_tval_i = $urandom;
      raddr_i = RA[ridx];
      #1;
      chk("rand_read", rdata_o, (dow && ridx == idx) ? mdl_write(idx, d) : mdl[ridx]);
      if (ev == 0) chk("rand_vec", trap_vec_o, mdl[2] & 32'hFFFF_FFFC);
      if (dow && !(ev <= 1 && (idx == 0 || idx == 3 || idx == 4 || idx == 5)))
        mdl[idx] = mdl_write(idx, d);
      if (ev == 0) begin
        mdl[0] = 32'h1800 | (mdl[0][3] ? 32'h80 : 32'h0);
        mdl[3] = trap_pc_i & 32'hFFFF_FFFC;
        mdl[4] = {28'h0, trap_cause_i};
        mdl[5] = trap_tval_i;
      end else if (ev == 1) begin
        mdl[0] = 32'h1880 | (mdl[0][7] ? 32'h8 : 32'h0);
      end
      tick();
    end
    we_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0;
    for (int i = 0; i < 8; i++) rchk("rand_final", RA[i], mdl[i]);

    // Counters (CNT_WIDTH = 40)
    wr(A_MCINH, 32'h0);
    wr(A_MCYCLE, 32'hFFFF_FFFF);
    rchk("mcycle_wr", A_MCYCLE, 32'hFFFF_FFFF);
    tick();
    rchk("mcycleh_carry", A_MCYCLEH, 32'h1);
    rchk("cycleh_alias", A_CYCLEH, 32'h1);
    rchk("mcycle_carry", A_MCYCLE, 32'h0);
    rchk("cycle_alias", A_CYCLE, 32'h0);
    we_i = 1'b1; waddr_i = A_MCYCLEH; wdata_i = 32'h1FF;
    rchk("mcycleh_bypass", A_MCYCLEH, 32'hFF);
    tick(); we_i = 1'b0;
    wr(A_MCYCLE, 32'hFFFF_FFFF);
    rchk("mcycleh_top", A_MCYCLEH, 32'hFF);
    rchk("mcycle_top", A_MCYCLE, 32'hFFFF_FFFF);
    tick();
    rchk("mcycleh_wrap", A_MCYCLEH, 32'h0);
    rchk("mcycle_wrap", A_MCYCLE, 32'h0);
    wr(A_MCINH, 32'hFFFF_FFFF);
    wr(A_MCYCLE, 32'd100);
    wr(A_MINSTRET, 32'd7);
    instret_incr_i = 1'b1;
    repeat (3) tick();
    rchk("inhibit_mcycle", A_MCYCLE, 32'd100);
    rchk("inhibit_minstret", A_MINSTRET, 32'd7);
    wr(A_MCINH, 32'h0);
    repeat (4) tick();
    rchk("run_mcycle", A_MCYCLE, 32'd104);
    rchk("run_minstret", A_MINSTRET, 32'd11);
    wr(A_MINSTRET, 32'd10);
    rchk("minstret_wr_wins", A_MINSTRET, 32'd10);
    repeat (3) tick();
    instret_incr_i = 1'b0;
    tick();
    rchk("minstret_count", A_MINSTRET, 32'd13);

    // Asynchronous reset mid-operation
    #3 rst_ni = 1'b0;
    rchk("arst_mcycle", A_MCYCLE, 32'h0);
    rchk("arst_mstatus", A_MSTATUS, 32'h1800);
    rchk("arst_mtvec", A_MTVEC, 32'h100);
    tick();
    rst_ni = 1'b1;
    rchk("release_mcycle", A_MCYCLE, 32'h0);
    tick();
    rchk("first_incr", A_MCYCLE, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
